output_enabler: RTL and testbench
=================================

Name: output_enabler

Overview:
- Tri-state output enable for a WIDTH-bit data bus.
- Passes in_bus onto out_bus when oe is asserted; releases out_bus to high-Z otherwise.
- Sits between an internal data source and a shared or external bus.
- Adds a registered status view and an enabled-transfer counter for observability.

Parameters:
- WIDTH, 8, bus width in bits (1..64).
- CNT_W, 8, width of the transfer counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_bus  input  WIDTH  source data.
- out_bus  output(tri)  WIDTH  driven copy of in_bus, or high-Z.
- oe  input  1  output enable, active-high: 1 = drive, 0 = high-Z.
- oe_active  output  1  registered: out_bus was driven during the last sampled cycle.
- last_data  output  WIDTH  registered: last value of in_bus sampled while driving.
- xfer_cnt  output  CNT_W  saturating count of enabled cycles in which in_bus changed.

Behaviour:
- Default build (macro undefined), bus path is combinational, zero latency:
  - out_bus = in_bus when rst_n=1 and oe=1.
  - out_bus = all-Z otherwise.
- Reset overrides enable: while rst_n=0, out_bus is all-Z regardless of oe.
- Reset is asynchronous, taking effect immediately and independent of clk. Reset values:
  - oe_active=0
  - last_data=0
  - xfer_cnt=0
  - internal previous-data register=0
- Any change on in_bus or oe propagates to out_bus within the same delta/time step. No glitch filtering.
- Every rising clk edge with rst_n=1:
  - oe_active <= oe.
  - If oe=1, last_data <= in_bus.
  - If oe=0, last_data holds its value.
  - If oe=1 and in_bus differs from the previous registered last_data, xfer_cnt increments by 1.
  - xfer_cnt saturates at all-ones and never wraps.
  - The first enabled cycle after reset compares against 0, so a nonzero in_bus counts as a change.
- Data changes while oe=0 are neither counted nor captured.
- An oe toggle with in_bus unchanged does not count.
- Reset asserted mid-operation:
  - out_bus goes to Z immediately.
  - All registers clear.
  - After deassertion, operation resumes on the next rising edge.
- No partial-bit enables: all WIDTH bits are driven or released together.

Optional Feature:
- Macro: OUTPUT_ENABLER_REGISTERED_EN.
- Defined:
  - out_bus is driven from registers.
  - A data register captures in_bus every rising edge; an enable register captures oe every rising edge.
  - out_bus = data register when the enable register is 1, else Z.
  - This gives exactly 1 clk cycle latency for both data and enable/disable.
  - Reset clears both registers, so out_bus is Z during and after reset until the first edge with oe=1.
  - Status outputs behave as in the default build.
- Undefined: combinational path as described in Behaviour.

Test Plan:
- Reset state: rst_n=0, in_bus=0x0A, oe=1 -> out_bus=Z, oe_active=0, last_data=0x00, xfer_cnt=0.
- Disabled bus: release reset; in_bus=0x0A, oe=0 for 5 cycles -> out_bus=Z, xfer_cnt=0, last_data=0x00.
- Enable: oe=1 for 5 cycles -> out_bus=0x0A immediately; after first edge oe_active=1, last_data=0x0A, xfer_cnt=1. oe=0 -> out_bus=Z.
- Change while disabled: oe=0; in_bus=0x1E, then in_bus=0x50 -> out_bus stays Z, last_data=0x0A, xfer_cnt=1. Then oe=1 -> out_bus=0x50, last_data=0x50 after edge, xfer_cnt=2.
- Saturation: CNT_W=2; toggle in_bus between 0x01 and 0x02 with oe=1 for 6 cycles -> xfer_cnt stops at 3.
- Async reset mid-drive, plus registered build: with oe=1 and out_bus=0x50, pulse rst_n low between edges -> out_bus=Z and all status cleared at once. With OUTPUT_ENABLER_REGISTERED_EN defined, oe rising -> out_bus leaves Z exactly one edge later; oe falling -> out_bus returns to Z one edge later.

Source files
------------

// File: rtl/output_enabler.sv
// output_enabler: tri-state driver for a WIDTH-bit bus with registered status and a saturating change counter.
// Define OUTPUT_ENABLER_REGISTERED_EN to drive out_bus from registers (one clk of latency for data and enable).
module output_enabler #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_bus,
    output tri   [WIDTH-1:0] out_bus,
    input  logic             oe,
    output logic             oe_active,
    output logic [WIDTH-1:0] last_data,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             drive_en;
    logic [WIDTH-1:0] drive_data;
    logic             data_changed;

`ifdef OUTPUT_ENABLER_REGISTERED_EN
    logic             en_q;
    logic [WIDTH-1:0] data_q;

    // Both registers clear asynchronously, so the bus is released during reset without extra gating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= 1'b0;
            data_q <= '0;
        end else begin
            en_q   <= oe;
            data_q <= in_bus;
        end
    end

    assign drive_en   = en_q;
    assign drive_data = data_q;
`else
    // Reset overrides enable on the combinational path.
    assign drive_en   = rst_n & oe;
    assign drive_data = in_bus;
`endif

    // All bits are driven or released together; there is no per-bit enable.
    assign out_bus = drive_en ? drive_data : {WIDTH{1'bz}};

    // last_data doubles as the previous-data reference; it clears to 0, so the first nonzero enabled value counts.
    assign data_changed = oe && (in_bus != last_data);

    // NOTE: non-blocking assignments keep every register reading the pre-edge value of last_data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oe_active <= 1'b0;
            last_data <= '0;
            xfer_cnt  <= '0;
        end else begin
            oe_active <= oe;
            if (oe) begin
                last_data <= in_bus;
            end
            if (data_changed && (xfer_cnt != CNT_MAX)) begin
                xfer_cnt <= xfer_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_output_enabler.sv
// Scoreboard bench for output_enabler: a stimulus process queues expected results, a monitor checks them each cycle.
// The bus net is pulled up, so a released bus reads as all-ones.
module tb_output_enabler;

    localparam int WIDTH   = 8;
    localparam int CNT_W   = 2;
    localparam int CNT_LIM = (1 << CNT_W) - 1;
    localparam logic [WIDTH-1:0] RELEASED = '1;

    typedef struct {
        logic [WIDTH-1:0] bus;
        logic             act;
        logic [WIDTH-1:0] last;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic [WIDTH-1:0] in_bus = '0;
    logic             oe     = 1'b0;
    tri1  [WIDTH-1:0] out_bus;
    logic             oe_active;
    logic [WIDTH-1:0] last_data;
    logic [CNT_W-1:0] xfer_cnt;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: what the block should hold after the most recent edge.
    logic             m_act  = 1'b0;
    logic [WIDTH-1:0] m_last = '0;
    int               m_cnt  = 0;
    logic             m_ereg = 1'b0;
    logic [WIDTH-1:0] m_dreg = '0;

    output_enabler #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_bus   (in_bus),
        .out_bus  (out_bus),
        .oe       (oe),
        .oe_active(oe_active),
        .last_data(last_data),
        .xfer_cnt (xfer_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // Applies one cycle of stimulus shortly after a rising edge and queues what the monitor should see mid-cycle.
    task automatic apply(input logic r, input logic e, input logic [WIDTH-1:0] d);
        exp_t x;
        @(posedge clk);
        #2;
        rst_n  = r;
        oe     = e;
        in_bus = d;
        if (!r) begin
            m_act  = 1'b0;
            m_last = '0;
            m_cnt  = 0;
            m_ereg = 1'b0;
            m_dreg = '0;
        end
`ifdef OUTPUT_ENABLER_REGISTERED_EN
        x.bus = m_ereg ? m_dreg : RELEASED;
`else
        x.bus = (r && e) ? d : RELEASED;
`endif
        x.act  = m_act;
        x.last = m_last;
        x.cnt  = CNT_W'(m_cnt);
        exp_q.push_back(x);
        // Effect of the coming edge, which sees these same inputs.
        if (r) begin
            m_act = e;
            if (e && (d != m_last) && (m_cnt < CNT_LIM)) m_cnt = m_cnt + 1;
            if (e) m_last = d;
            m_dreg = d;
            m_ereg = e;
        end
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("out_bus",   64'(out_bus),   64'(x.bus));
                check("oe_active", 64'(oe_active), 64'(x.act));
                check("last_data", 64'(last_data), 64'(x.last));
                check("xfer_cnt",  64'(xfer_cnt),  64'(x.cnt));
            end
        end
    end

    initial begin : stimulus
        logic [WIDTH-1:0] prev;
        logic [WIDTH-1:0] d;
        int               wait_cycles;

        // Reset dominates an asserted enable.
        apply(1'b0, 1'b1, 8'h0A);
        // Disabled bus after reset.
        repeat (5) apply(1'b1, 1'b0, 8'h0A);
        // Enable: first enabled edge compares against 0 and counts.
        repeat (5) apply(1'b1, 1'b1, 8'h0A);
        apply(1'b1, 1'b0, 8'h0A);
        // Changes while disabled are neither captured nor counted.
        apply(1'b1, 1'b0, 8'h1E);
        apply(1'b1, 1'b0, 8'h50);
        apply(1'b1, 1'b1, 8'h50);
        apply(1'b1, 1'b1, 8'h50);
        // oe toggle with unchanged data does not count.
        apply(1'b1, 1'b0, 8'h50);
        apply(1'b1, 1'b1, 8'h50);
        // Saturation: the 2-bit counter stops at 3.
        for (int i = 0; i < 6; i++) apply(1'b1, 1'b1, (i % 2 == 0) ? 8'h01 : 8'h02);
        apply(1'b1, 1'b1, 8'h01);
        // Reset pulsed between edges while driving.
        apply(1'b1, 1'b1, 8'h50);
        apply(1'b0, 1'b1, 8'h50);
        apply(1'b1, 1'b1, 8'h50);
        apply(1'b1, 1'b1, 8'h50);
        // Enable rise and fall with steady data.
        apply(1'b1, 1'b0, 8'h33);
        apply(1'b1, 1'b1, 8'h33);
        apply(1'b1, 1'b1, 8'h33);
        apply(1'b1, 1'b0, 8'h33);
        apply(1'b1, 1'b0, 8'h33);

        // Random traffic with occasional resets and frequent repeated data.
        prev = 8'h33;
        for (int i = 0; i < 400; i++) begin
            d = ($urandom_range(0, 2) == 0) ? prev : WIDTH'($urandom);
            apply(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)), d);
            prev = d;
        end
        apply(1'b1, 1'b0, prev);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
